// File: rtl/hjscope.sv
// Logic-analyser style probe capture with a register-mapped trigger and readout port.
// Register access: 1-cycle ack; DATA reads ack 3 cycles after the request.
module hjscope #(
    parameter  int N   = 8,
    parameter  int SIZ = 1024,
    localparam int NW  = (N + 31) / 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          regreq,
    input  logic          regwr,
    input  logic [15:0]   regaddr,
    input  logic [31:0]   regwdata,
    output logic          regack,
    output logic          regerr,
    output logic [31:0]   regrdata,
    input  logic [N-1:0]  in
);
    localparam int AW = $clog2(SIZ);
    localparam int W  = NW * 32;
    localparam logic [W-1:0] PADM = W'({N{1'b1}});

    logic [N-1:0]  smem [SIZ];
    logic [N-1:0]  dsamp_q;

    logic          running_q, running_d, avail_q, avail_d, trig_q, trig_d, first_q, first_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, tptr_q, tptr_d;
    logic [7:0]    wcnt_q, wcnt_d, dsel_q, dsel_d;
    logic [31:0]   mcnt_q, mcnt_d, tcnt_q, tcnt_d, tsel_q, tsel_d;
    logic [15:0]   scnt_q, scnt_d, post_q, post_d, pre_q, pre_d;
    logic          trans_q, trans_d;
    logic [W-1:0]  tval_q, tval_d, tmask_q, tmask_d, tedge_q, tedge_d;
    logic [N-1:0]  prev_q, prev_d;
    logic          regack_q, regack_d, regerr_q, regerr_d;
    logic [31:0]   regrdata_q, regrdata_d, dword_q, dword_d;
    logic          dp1_q, dp1_d, dp2_q, dp2_d;

    logic [13:0]   widx;
    logic          store, hit, done, rd_fire;
    logic [N-1:0]  bmatch;
    logic [31:0]   tgt, rd;
    logic [W-1:0]  dpad;
    logic [1:0]    unused_addr;

    assign widx        = regaddr[15:2];
    assign unused_addr = regaddr[1:0];
    assign regack      = regack_q;
    assign regerr      = regerr_q;
    assign regrdata    = regrdata_q;

    assign store   = running_q & (~trans_q | first_q | (in != prev_q));
    assign bmatch  = ~tmask_q[N-1:0] | (~(in ^ tval_q[N-1:0]) & (~tedge_q[N-1:0] | (in ^ prev_q)));
    assign hit     = &bmatch;
    assign tgt     = (tcnt_q == 32'd0) ? 32'd1 : tcnt_q;
    assign rd_fire = regreq & ~regwr & (widx == 14'd2) & avail_q;
    assign dpad    = W'(dsamp_q);

    always_comb begin
        running_d = running_q;  avail_d = avail_q;  trig_d = trig_q;  first_d = first_q;
        wptr_d = wptr_q;  rptr_d = rptr_q;  tptr_d = tptr_q;  wcnt_d = wcnt_q;
        mcnt_d = mcnt_q;  scnt_d = scnt_q;  post_d = post_q;  pre_d = pre_q;
        trans_d = trans_q;  tsel_d = tsel_q;  tcnt_d = tcnt_q;
        tval_d = tval_q;  tmask_d = tmask_q;  tedge_d = tedge_q;
        prev_d = in;
        regack_d = 1'b0;  regerr_d = 1'b0;  regrdata_d = '0;
        dp1_d = 1'b0;  dp2_d = dp1_q;  dsel_d = dsel_q;  dword_d = dword_q;
        done = 1'b0;  rd = '0;

        // Capture and trigger evaluation always use the configuration in force before this cycle's write.
        if (store) begin
            wptr_d  = wptr_q + 1'b1;
            first_d = 1'b0;
            if (scnt_q < pre_q) scnt_d = scnt_q + 16'd1;
            if (!trig_q) begin
                if (scnt_q >= pre_q && hit) begin
                    mcnt_d = mcnt_q + 32'd1;
                    if (mcnt_q + 32'd1 >= tgt) begin
                        trig_d = 1'b1;
                        tptr_d = wptr_q;
                        if (int'(pre_q) == SIZ - 1) done = 1'b1;
                        else post_d = 16'(SIZ - 1 - int'(pre_q));
                    end
                end
            end else begin
                post_d = post_q - 16'd1;
                if (post_q == 16'd1) done = 1'b1;
            end
            if (done) begin
                running_d = 1'b0;
                avail_d   = 1'b1;
                rptr_d    = (trig_q ? tptr_q : wptr_q) - AW'(pre_q);
                wcnt_d    = 8'd0;
            end
        end

        if (dp1_q) begin
            for (int k = 0; k < NW; k++)
                if (dsel_q == 8'(k)) dword_d = dpad[k*32 +: 32];
        end
        if (dp2_q) begin
            regack_d   = 1'b1;
            regrdata_d = dword_q;
        end

        if (regreq) begin
            regack_d = 1'b1;
            case (widx)
                14'd0: begin
                    if (regwr) begin
                        trans_d = regwdata[1];
                        pre_d   = (regwdata[31:16] > 16'(SIZ - 1)) ? 16'(SIZ - 1) : regwdata[31:16];
                        if (regwdata[2]) begin
                            running_d = 1'b0;
                            avail_d   = 1'b0;
                        end else if (regwdata[0]) begin
                            running_d = 1'b1;  avail_d = 1'b0;  trig_d = 1'b0;  first_d = 1'b1;
                            wptr_d = '0;  mcnt_d = '0;  scnt_d = '0;  post_d = '0;
                        end
                    end else begin
                        rd = {16'(wptr_q), 13'd0, trig_q, running_q, avail_q};
                    end
                end
                14'd1: begin
                    regerr_d = regwr;
                    rd = 32'(N);
                end
                14'd2: begin
                    if (regwr || !avail_q) begin
                        regerr_d = 1'b1;
                    end else begin
                        regack_d = 1'b0;
                        dp1_d    = 1'b1;
                        dsel_d   = wcnt_q;
                        if (wcnt_q == 8'(NW - 1)) begin
                            wcnt_d = 8'd0;
                            rptr_d = rptr_q + 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + 8'd1;
                        end
                    end
                end
                14'd3: begin
                    regerr_d = regwr;
                    rd = 32'(SIZ);
                end
                14'd4: begin
                    if (regwr) tsel_d = regwdata;
                    rd = tsel_q;
                end
                14'd5, 14'd6, 14'd7: begin
                    if (tsel_q >= 32'(NW)) begin
                        regerr_d = 1'b1;
                    end else begin
                        for (int k = 0; k < NW; k++) begin
                            if (tsel_q == 32'(k)) begin
                                if (widx == 14'd5) begin
                                    rd = tval_q[k*32 +: 32];
                                    if (regwr) tval_d[k*32 +: 32] = regwdata;
                                end else if (widx == 14'd6) begin
                                    rd = tmask_q[k*32 +: 32];
                                    if (regwr) tmask_d[k*32 +: 32] = regwdata;
                                end else begin
                                    rd = tedge_q[k*32 +: 32];
                                    if (regwr) tedge_d[k*32 +: 32] = regwdata;
                                end
                            end
                        end
                        tval_d  = tval_d & PADM;
                        tmask_d = tmask_d & PADM;
                        tedge_d = tedge_d & PADM;
                    end
                end
                14'd8: begin
                    if (regwr) tcnt_d = regwdata;
                    rd = tcnt_q;
                end
                default: regerr_d = 1'b1;
            endcase
            if (!regwr && !regerr_d) regrdata_d = rd;
        end
    end

    // Sample RAM is deliberately left out of reset so a capture survives it.
    always_ff @(posedge clk) begin
        if (store)   smem[wptr_q] <= in;
        if (rd_fire) dsamp_q <= smem[rptr_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running_q <= 1'b0;  avail_q <= 1'b0;  trig_q <= 1'b0;  first_q <= 1'b0;
            wptr_q <= '0;  rptr_q <= '0;  tptr_q <= '0;  wcnt_q <= '0;  dsel_q <= '0;
            mcnt_q <= '0;  scnt_q <= '0;  post_q <= '0;  pre_q <= '0;  trans_q <= 1'b0;
            tsel_q <= '0;  tcnt_q <= '0;  tval_q <= '0;  tmask_q <= '0;  tedge_q <= '0;
            prev_q <= '0;  regack_q <= 1'b0;  regerr_q <= 1'b0;  regrdata_q <= '0;
            dword_q <= '0;  dp1_q <= 1'b0;  dp2_q <= 1'b0;
        end else begin
            running_q <= running_d;  avail_q <= avail_d;  trig_q <= trig_d;  first_q <= first_d;
            wptr_q <= wptr_d;  rptr_q <= rptr_d;  tptr_q <= tptr_d;  wcnt_q <= wcnt_d;  dsel_q <= dsel_d;
            mcnt_q <= mcnt_d;  scnt_q <= scnt_d;  post_q <= post_d;  pre_q <= pre_d;  trans_q <= trans_d;
            tsel_q <= tsel_d;  tcnt_q <= tcnt_d;  tval_q <= tval_d;  tmask_q <= tmask_d;  tedge_q <= tedge_d;
            prev_q <= prev_d;  regack_q <= regack_d;  regerr_q <= regerr_d;  regrdata_q <= regrdata_d;
            dword_q <= dword_d;  dp1_q <= dp1_d;  dp2_q <= dp2_d;
        end
    end
endmodule

// File: doc/hjscope.md
HJSCOPE -- requirements
Module: hjscope

Interface
REQ-001 Parameter N, default 8: probe width in bits, 1..256.
REQ-002 Parameter SIZ, default 1024: sample buffer depth in samples, power of two, 16..65536.
REQ-003 Parameter NW, derived as (N+31)/32: 32-bit words per sample; not overridable.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 regreq  in  1  register request strobe, one cycle per access.
REQ-007 regwr  in  1  1 = write, 0 = read; qualified by regreq.
REQ-008 regaddr  in  16  byte address; bits [1:0] ignored.
REQ-009 regwdata  in  32  write data.
REQ-010 regack  out  1  one-cycle completion pulse per request.
REQ-011 regerr  out  1  valid with regack; 1 = unmapped address or illegal access.
REQ-012 regrdata  out  32  read data, valid with regack.
REQ-013 in  in  N  probe inputs, synchronous to clk.

Function
REQ-014 Register map: 0 CTRL/STATUS; 4 N (RO); 8 DATA (RO); 12 SIZ (RO); 16 TSEL (RW); 20 TVAL (RW); 24 TMASK (RW); 28 TEDGE (RW); 32 TCNT (RW); any other address -> regerr=1.
REQ-015 CTRL write: bit0 start, bit1 trans, bit2 abort, [31:16] pre (pre-trigger sample count, clamped to SIZ-1).
REQ-016 STATUS read: bit0 avail, bit1 running, bit2 triggered, [31:16] wptr.
REQ-017 TSEL selects word index k; TVAL/TMASK/TEDGE access bits [32k+31:32k] of the value/mask/edge vectors; k >= NW -> regerr=1; bits beyond N read 0.
REQ-018 Non-DATA accesses: regack exactly 1 cycle after the regreq cycle.
REQ-019 DATA read: regack exactly 3 cycles after the regreq cycle; returns the next 32-bit word of the current readout sample, least significant word first, zero-padded above N.
REQ-020 After word NW-1 of a sample is read, the read pointer advances by one modulo SIZ.
REQ-021 DATA read while avail=0 -> regerr=1 with 1-cycle ack; pointers unchanged.
REQ-022 Start: running=1, avail=0, triggered=0, wptr=0, match counter=0, stored count=0.
REQ-023 Sample stored when running and (trans=0, or first cycle after start, or in differs from its previous-cycle value).
REQ-024 Bit match: TMASK=0 -> don't care; TMASK=1 and TEDGE=0 -> in==TVAL; TMASK=1 and TEDGE=1 -> in==TVAL and bit changed since last cycle.
REQ-025 Match = all bits match; evaluated on the stored sample only.
REQ-026 Trigger arms only after pre samples are stored; each armed match increments the match counter; trigger fires when counter reaches TCNT (TCNT=0 treated as 1).
REQ-027 After trigger: triggered=1; capture continues for exactly SIZ-1-pre further stored samples, then running=0, avail=1.
REQ-028 wptr wraps SIZ-1 -> 0; pre-trigger data may be overwritten until trigger.
REQ-029 On avail, read pointer = oldest sample (trigger sample located at index pre); word counter=0.
REQ-030 Start while running restarts capture; abort clears running and avail without altering buffer contents; start and abort in the same write -> abort wins.
REQ-031 Config register writes while running take effect from the next stored sample.

Reset
REQ-032 rstn=0 clears, asynchronously: running, avail, triggered, wptr, rptr, word counter, match counter, regack, regerr, regrdata, TSEL, TVAL, TMASK, TEDGE, TCNT, pre, trans.
REQ-033 Reset during readout or during a pending DATA ack drops that ack; buffer RAM is not cleared.

Verification
REQ-034 N=8, SIZ=16, pre=4, TMASK=FF, TVAL=0x20, counting ramp input -> trigger at 0x20, avail after 11 more samples; readout gives 0x1C..0x2B in order.
REQ-035 N=40, TVAL/TMASK on word 1 only -> each DATA read pair returns bits [31:0] then [39:32] zero-padded; ack at +3 cycles.
REQ-036 trans=1, input held 0x5 for 10 cycles, then toggled 0x5/0x6 -> one 0x5 entry, then one entry per change.
REQ-037 TCNT=3, TEDGE bit0=1, TVAL bit0=1 -> triggers on the third rising edge only.
REQ-038 Read 0x40 -> regerr=1; DATA read before avail -> regerr=1; TSEL=NW -> TVAL access errors.
REQ-039 rstn pulsed low mid-capture -> STATUS reads 0, next start captures normally.
